vital_alarm_controller: RTL and testbench

Parametrised successor to the heart monitoring system: classifies streamed heart-rate/SpO2 samples and confirms bradycardia or tachycardia only after a programmable run of consecutive abnormal samples. It drives CPR, and hands off a weight/age-scaled drug dose to the infusion pump over a valid/ready handshake. A cooldown lockout follows every intervention. Sits between the sensor front-end and the CPR/pump actuators.

---
 rtl/vital_pkg.sv | 37 +++
 rtl/vital_alarm_controller_dose_calc.sv | 34 +++
 rtl/vital_alarm_controller.sv | 200 ++++++++++++++++++++
 tb/tb_vital_alarm_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vital_pkg.sv
// vital_pkg: shared types and constants for the vital alarm controller.
//   - vital_state_e : controller state, encoding is visible on alarm_state
//   - vital_class_e : per-sample classification
//   - dose weight constants used by dose_calc
//   - max3          : helper for sizing shared counters
package vital_pkg;

   typedef enum logic [1:0] {
      ST_MONITOR  = 2'd0,
      ST_CPR      = 2'd1,
      ST_DOSE     = 2'd2,
      ST_COOLDOWN = 2'd3
   } vital_state_e;

   typedef enum logic [1:0] {
      CLS_NORMAL = 2'd0,
      CLS_BRADY  = 2'd1,
      CLS_TACHY  = 2'd2
   } vital_class_e;

   // Dose = BASE + MED*(wt>=WT_MED) + HIGH*(wt>=WT_HIGH) + AGE*(age>=AGE_SENIOR)
   localparam int unsigned DOSE_BASE   = 1;
   localparam int unsigned DOSE_WT_MED = 1;
   localparam int unsigned DOSE_WT_HI  = 2;
   localparam int unsigned DOSE_AGE    = 1;
   // Widest possible unsaturated sum (5) fits in this many bits
   localparam int unsigned DOSE_SUM_W  = 4;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/vital_alarm_controller_dose_calc.sv
// dose_calc: combinational weight/age to drug dose, saturated to DOSE_W bits.
// Ports:
//   i_weight  in  W       patient weight
//   i_age     in  W       patient age
//   o_dose    out DOSE_W  saturated dose
module dose_calc
   import vital_pkg::*;
#(
   parameter int unsigned W          = 8,
   parameter int unsigned DOSE_W     = 4,
   parameter int unsigned WT_MED     = 60,
   parameter int unsigned WT_HIGH    = 80,
   parameter int unsigned AGE_SENIOR = 60
) (
   input  logic [W-1:0]      i_weight,
   input  logic [W-1:0]      i_age,
   output logic [DOSE_W-1:0] o_dose
);

   localparam int unsigned DOSE_MAX = (1 << DOSE_W) - 1;

   logic [DOSE_SUM_W-1:0] w_sum;

   always_comb begin
      w_sum = DOSE_SUM_W'(DOSE_BASE);
      if (i_weight >= W'(WT_MED))     w_sum = w_sum + DOSE_SUM_W'(DOSE_WT_MED);
      if (i_weight >= W'(WT_HIGH))    w_sum = w_sum + DOSE_SUM_W'(DOSE_WT_HI);
      if (i_age    >= W'(AGE_SENIOR)) w_sum = w_sum + DOSE_SUM_W'(DOSE_AGE);
   end

   // Clamp to the largest value the output width can carry
   assign o_dose = (32'(w_sum) > DOSE_MAX) ? DOSE_W'(DOSE_MAX) : DOSE_W'(w_sum);

endmodule

// File: rtl/vital_alarm_controller.sv
// vital_alarm_controller: classifies heart-rate/SpO2 samples, confirms
// bradycardia (CPR) or tachycardia (drug dose via valid/ready) after PERSIST
// consecutive abnormal samples, and locks out for COOLDOWN_CYC clocks after
// every intervention.
// Optional feature: define SPO2_CHECK_EN to treat oxygen_level < SPO2_LOW as
// BRADY; without it oxygen_level is ignored.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   sample_valid             sample inputs valid this cycle
//   heart_rate, oxygen_level, patient_weight, patient_age   W-bit sample
//   pump_ready               pump accepts dose
//   cpr_activate             CPR drive
//   drug_delivery_activate   dose request (valid)
//   drug_dosage              dose, stable while request high
//   alarm_state              0 MONITOR, 1 CPR, 2 DOSE, 3 COOLDOWN
//   doses_delivered          saturating count of completed handshakes
module vital_alarm_controller
   import vital_pkg::*;
#(
   parameter int unsigned W            = 8,
   parameter int unsigned DOSE_W       = 4,
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned HR_LOW       = 50,
   parameter int unsigned HR_HIGH      = 120,
   parameter int unsigned SPO2_LOW     = 90,
   parameter int unsigned WT_MED       = 60,
   parameter int unsigned WT_HIGH      = 80,
   parameter int unsigned AGE_SENIOR   = 60,
   parameter int unsigned PERSIST      = 4,
   parameter int unsigned RECOVER      = 4,
   parameter int unsigned COOLDOWN_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid,
   input  logic [W-1:0]      heart_rate,
   input  logic [W-1:0]      oxygen_level,
   input  logic [W-1:0]      patient_weight,
   input  logic [W-1:0]      patient_age,
   input  logic              pump_ready,
   output logic              cpr_activate,
   output logic              drug_delivery_activate,
   output logic [DOSE_W-1:0] drug_dosage,
   output logic [1:0]        alarm_state,
   output logic [CNT_W-1:0]  doses_delivered
);

   // One counter serves persistence, recovery and cooldown; size for the largest
   localparam int unsigned SEQ_MAX = max3(PERSIST, RECOVER, COOLDOWN_CYC);
   localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
   localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

   vital_state_e        r_state;
   vital_class_e        r_last_cls;
   logic [SEQ_W-1:0]    r_cnt;
   logic                r_cpr;
   logic                r_req;
   logic [DOSE_W-1:0]   r_dosage;
   logic [CNT_W-1:0]    r_doses;

   vital_class_e        w_cls;
   logic                w_brady;
   logic [SEQ_W-1:0]    w_cnt_inc;
   logic [SEQ_W-1:0]    w_mon_cnt;
   logic [DOSE_W-1:0]   w_dose;

   // Sample classification; BRADY takes precedence over TACHY
   always_comb begin
      w_brady = (heart_rate < W'(HR_LOW));
`ifdef SPO2_CHECK_EN
      w_brady = w_brady || (oxygen_level < W'(SPO2_LOW));
`endif
      if (w_brady)                      w_cls = CLS_BRADY;
      else if (heart_rate > W'(HR_HIGH)) w_cls = CLS_TACHY;
      else                              w_cls = CLS_NORMAL;
   end

`ifndef SPO2_CHECK_EN
   logic w_unused_spo2;
   assign w_unused_spo2 = ^{oxygen_level, W'(SPO2_LOW)};
`endif

   assign w_cnt_inc = r_cnt + SEQ_ONE;

   // Run length of the current abnormal class; restarts at 1 on a class change
   always_comb begin
      if (w_cls == CLS_NORMAL)      w_mon_cnt = '0;
      else if (w_cls == r_last_cls) w_mon_cnt = w_cnt_inc;
      else                          w_mon_cnt = SEQ_ONE;
   end

   dose_calc #(
      .W          (W),
      .DOSE_W     (DOSE_W),
      .WT_MED     (WT_MED),
      .WT_HIGH    (WT_HIGH),
      .AGE_SENIOR (AGE_SENIOR)
   ) u_dose_calc (
      .i_weight (patient_weight),
      .i_age    (patient_age),
      .o_dose   (w_dose)
   );

   // Controller FSM with registered Moore outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_MONITOR;
         r_last_cls <= CLS_NORMAL;
         r_cnt      <= '0;
         r_cpr      <= 1'b0;
         r_req      <= 1'b0;
         r_dosage   <= '0;
         r_doses    <= '0;
      end else begin
         case (r_state)
            ST_MONITOR: begin
               if (sample_valid) begin
                  r_last_cls <= w_cls;
                  if (w_mon_cnt == SEQ_W'(PERSIST)) begin
                     r_cnt <= '0;
                     if (w_cls == CLS_BRADY) begin
                        r_state <= ST_CPR;
                        r_cpr   <= 1'b1;
                     end else begin
                        r_state  <= ST_DOSE;
                        r_req    <= 1'b1;
                        r_dosage <= w_dose;
                     end
                  end else begin
                     r_cnt <= w_mon_cnt;
                  end
               end
            end

            ST_DOSE: begin
               // A completed transfer wins over a simultaneous BRADY confirmation
               if (r_req && pump_ready) begin
                  r_state  <= ST_COOLDOWN;
                  r_req    <= 1'b0;
                  r_dosage <= '0;
                  r_cnt    <= '0;
                  if (r_doses != {CNT_W{1'b1}}) r_doses <= r_doses + CNT_W'(1);
               end else if (sample_valid) begin
                  if (w_cls == CLS_BRADY) begin
                     if (w_cnt_inc == SEQ_W'(PERSIST)) begin
                        r_state  <= ST_CPR;
                        r_req    <= 1'b0;
                        r_dosage <= '0;
                        r_cpr    <= 1'b1;
                        r_cnt    <= '0;
                     end else begin
                        r_cnt <= w_cnt_inc;
                     end
                  end else begin
                     r_cnt <= '0;
                  end
               end
            end

            ST_CPR: begin
               if (sample_valid) begin
                  if (w_cls == CLS_NORMAL) begin
                     if (w_cnt_inc == SEQ_W'(RECOVER)) begin
                        r_state <= ST_COOLDOWN;
                        r_cpr   <= 1'b0;
                        r_cnt   <= '0;
                     end else begin
                        r_cnt <= w_cnt_inc;
                     end
                  end else begin
                     r_cnt <= '0;
                  end
               end
            end

            ST_COOLDOWN: begin
               if (w_cnt_inc == SEQ_W'(COOLDOWN_CYC)) begin
                  r_state    <= ST_MONITOR;
                  r_last_cls <= CLS_NORMAL;
                  r_cnt      <= '0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            default: begin
               r_state <= ST_MONITOR;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign cpr_activate           = r_cpr;
   assign drug_delivery_activate = r_req;
   assign drug_dosage            = r_dosage;
   assign alarm_state            = r_state;
   assign doses_delivered        = r_doses;

endmodule

// File: tb/tb_vital_alarm_controller.sv
// tb_vital_alarm_controller: directed test-plan sequences followed by random
// stimulus, checked every cycle against a sample-history reference model.
// A second instance with DOSE_W=2 checks dose saturation.
module tb_vital_alarm_controller;

   localparam int P  = 4;
   localparam int R  = 4;
   localparam int CD = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_valid;
   logic [7:0] heart_rate, oxygen_level, patient_weight, patient_age;
   logic       pump_ready;

   logic       cpr_activate, drug_delivery_activate;
   logic [3:0] drug_dosage;
   logic [1:0] alarm_state;
   logic [7:0] doses_delivered;

   logic       cpr2, req2;
   logic [1:0] dosage2;
   logic [1:0] state2;
   logic [7:0] doses2;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: state as the spec's numbering, class history since entry
   int m_state;
   int m_hist[$];
   int m_cool;
   int m_dose_raw;
   int m_doses;

   always #5 clk = ~clk;

   vital_alarm_controller u_dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid),
      .heart_rate(heart_rate), .oxygen_level(oxygen_level),
      .patient_weight(patient_weight), .patient_age(patient_age),
      .pump_ready(pump_ready), .cpr_activate(cpr_activate),
      .drug_delivery_activate(drug_delivery_activate),
      .drug_dosage(drug_dosage), .alarm_state(alarm_state),
      .doses_delivered(doses_delivered)
   );

   vital_alarm_controller #(.DOSE_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .sample_valid(sample_valid),
      .heart_rate(heart_rate), .oxygen_level(oxygen_level),
      .patient_weight(patient_weight), .patient_age(patient_age),
      .pump_ready(pump_ready), .cpr_activate(cpr2),
      .drug_delivery_activate(req2),
      .drug_dosage(dosage2), .alarm_state(state2),
      .doses_delivered(doses2)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // 0 NORMAL, 1 BRADY, 2 TACHY
   function automatic int cls_of(input int h, input int o);
      bit b;
      b = (h < 50);
`ifdef SPO2_CHECK_EN
      b = b || (o < 90);
`else
      if (o < 0) b = 1'b0;
`endif
      if (b) return 1;
      if (h > 120) return 2;
      return 0;
   endfunction

   function automatic int dose_of(input int w, input int a);
      return 1 + ((w >= 60) ? 1 : 0) + ((w >= 80) ? 2 : 0) + ((a >= 60) ? 1 : 0);
   endfunction

   function automatic int sat(input int d, input int dw);
      int mx;
      mx = (1 << dw) - 1;
      return (d > mx) ? mx : d;
   endfunction

   function automatic bit last_all(input int n, input int c);
      if (m_hist.size() < n) return 1'b0;
      for (int i = 0; i < n; i++)
         if (m_hist[m_hist.size() - 1 - i] != c) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step();
      int c;
      c = cls_of(heart_rate, oxygen_level);
      if (rst) begin
         m_state = 0; m_hist.delete(); m_cool = 0; m_dose_raw = 0; m_doses = 0;
         return;
      end
      case (m_state)
         0: if (sample_valid) begin
               m_hist.push_back(c);
               if (last_all(P, 1)) begin
                  m_state = 1; m_hist.delete();
               end else if (last_all(P, 2)) begin
                  m_state = 2; m_hist.delete();
                  m_dose_raw = dose_of(patient_weight, patient_age);
               end
            end
         2: if (pump_ready) begin
               if (m_doses < 255) m_doses++;
               m_state = 3; m_cool = 0; m_hist.delete();
            end else if (sample_valid) begin
               m_hist.push_back(c);
               if (last_all(P, 1)) begin
                  m_state = 1; m_hist.delete();
               end
            end
         1: if (sample_valid) begin
               m_hist.push_back(c);
               if (last_all(R, 0)) begin
                  m_state = 3; m_cool = 0; m_hist.delete();
               end
            end
         default: begin
               m_cool++;
               if (m_cool == CD) m_state = 0;
            end
      endcase
   endtask

   task automatic compare_all();
      check("alarm_state", alarm_state, m_state);
      check("cpr_activate", cpr_activate, (m_state == 1) ? 1 : 0);
      check("drug_req", drug_delivery_activate, (m_state == 2) ? 1 : 0);
      check("drug_dosage", drug_dosage, (m_state == 2) ? sat(m_dose_raw, 4) : 0);
      check("doses_delivered", doses_delivered, m_doses);
      check("dosage_w2", dosage2, (m_state == 2) ? sat(m_dose_raw, 2) : 0);
   endtask

   task automatic step(input bit v, input int h, input int o, input int w,
                       input int a, input bit rdy, input bit rs);
      sample_valid   = v;
      heart_rate     = 8'(h);
      oxygen_level   = 8'(o);
      patient_weight = 8'(w);
      patient_age    = 8'(a);
      pump_ready     = rdy;
      rst            = rs;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic samples(input int n, input int h, input int o, input int w,
                          input int a);
      for (int i = 0; i < n; i++) step(1'b1, h, o, w, a, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(1'b0, 80, 98, 70, 30, rdy, 1'b0);
   endtask

   int h_cur;

   initial begin
      // Reset
      step(1'b0, 80, 98, 70, 30, 1'b0, 1'b1);
      step(1'b0, 80, 98, 70, 30, 1'b1, 1'b1);
      check("rst_state", alarm_state, 0);
      check("rst_doses", doses_delivered, 0);

      // Bradycardia -> CPR -> recovery -> cooldown -> monitor
      samples(3, 45, 98, 70, 30);
      check("brady_3rd_no_cpr", cpr_activate, 0);
      samples(1, 45, 98, 70, 30);
      check("brady_cpr", cpr_activate, 1);
      samples(4, 80, 98, 70, 30);
      check("recover_cooldown", alarm_state, 3);
      idle(15, 1'b1);
      check("cooldown_15", alarm_state, 3);
      idle(1, 1'b0);
      check("cooldown_done", alarm_state, 0);

      // Tachycardia -> dose 2, stalled pump, then handshake
      samples(4, 130, 98, 60, 40);
      check("tachy_req", drug_delivery_activate, 1);
      check("tachy_dose", drug_dosage, 2);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 80, 98, 10, 10, 1'b0, 1'b0);
         check("stall_req", drug_delivery_activate, 1);
         check("stall_dose", drug_dosage, 2);
      end
      step(1'b0, 80, 98, 70, 30, 1'b1, 1'b0);
      check("hs_count", doses_delivered, 1);
      check("hs_cooldown", alarm_state, 3);
      idle(CD, 1'b0);

      // Maximum dose and saturation at DOSE_W=2
      samples(4, 125, 98, 90, 65);
      check("dose_max", drug_dosage, 5);
      check("dose_sat_w2", dosage2, 3);
      idle(1, 1'b1);
      idle(CD, 1'b0);

      // Alternating classes, boundaries and gaps never confirm
      for (int k = 0; k < 3; k++) begin
         samples(1, 130, 98, 70, 30);
         idle(1, 1'b1);
         samples(1, 45, 98, 70, 30);
         samples(1, 130, 98, 70, 30);
      end
      for (int k = 0; k < 4; k++) begin
         samples(1, 50, 98, 70, 30);
         idle(2, 1'b0);
         samples(1, 120, 98, 70, 30);
      end
      check("no_confirm", alarm_state, 0);

      // BRADY confirmation aborts a pending dose, then reset mid-CPR
      samples(4, 130, 98, 70, 30);
      check("abort_pre_req", drug_delivery_activate, 1);
      samples(4, 30, 98, 70, 30);
      check("abort_req_low", drug_delivery_activate, 0);
      check("abort_cpr", cpr_activate, 1);
      check("abort_no_count", doses_delivered, 2);
      step(1'b1, 30, 98, 70, 30, 1'b0, 1'b1);
      check("rst_cpr", cpr_activate, 0);
      check("rst_cpr_doses", doses_delivered, 0);
      check("rst_cpr_state", alarm_state, 0);

      // Hypoxia with normal heart rate
      samples(4, 80, 85, 70, 30);
`ifdef SPO2_CHECK_EN
      check("hypoxia_cpr", cpr_activate, 1);
      samples(4, 80, 98, 70, 30);
      idle(CD, 1'b0);
`else
      check("hypoxia_ignored", alarm_state, 0);
`endif

      // Random stimulus with sticky heart-rate regions to produce runs
      h_cur = 80;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 9) < 3) begin
            case ($urandom_range(0, 5))
               0:       h_cur = 20 + int'($urandom_range(0, 29));
               1:       h_cur = 50;
               2:       h_cur = 120;
               3:       h_cur = 121 + int'($urandom_range(0, 79));
               default: h_cur = 51 + int'($urandom_range(0, 68));
            endcase
         end
         step($urandom_range(0, 3) != 0, h_cur, int'($urandom_range(80, 100)),
              int'($urandom_range(30, 110)), int'($urandom_range(10, 90)),
              $urandom_range(0, 9) < 2, $urandom_range(0, 299) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
